pulse_sequencer: RTL and testbench

Parametrised, table-driven pulse sequencer. It generates multi-channel pulse trains (reset/write/measure sequences and similar) from a programmable step table. Each step holds an output pattern and a duration. The block supports a programmable step count, a repeat count or continuous mode, start/abort control and status outputs. It sits between the host register file and the pulse output drivers, and generalises the fixed 12-step, 8-bit hard-coded pulse controller.

---
 rtl/pulse_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pulse_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: table-driven multi-channel pulse train generator.
// Each table entry holds an output pattern and a duration code D; a step
// lasts D+1 cycles. Runs a programmable number of steps per pass, for a
// finite number of passes or continuously, with start/abort control.
module pulse_sequencer #(
  parameter int                DUR_W        = 22,
  parameter int                OUT_W        = 8,
  parameter int                DEPTH        = 16,
  parameter int                AW           = $clog2(DEPTH),
  parameter logic [OUT_W-1:0]  IDLE_PATTERN = 8'h80
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic [OUT_W-1:0]  cfg_pattern,
  input  logic [AW:0]       num_steps,
  input  logic [15:0]       repeat_count,
  input  logic              start,
  input  logic              abort,
  output logic [OUT_W-1:0]  signal_out,
  output logic              busy,
  output logic [AW-1:0]     step_index,
  output logic              step_strobe,
  output logic              done
);

  localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      STEP_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [DUR_W-1:0] dur_mem [DEPTH];
  logic [OUT_W-1:0] pat_mem [DEPTH];

  logic [DUR_W-1:0] cnt, cnt_nx;
  logic [AW-1:0]    last, last_nx;
  logic [15:0]      passes, passes_nx;
  logic             cont, cont_nx;
  logic [OUT_W-1:0] out_nx;
  logic             busy_nx, strobe_nx, done_nx;
  logic [AW-1:0]    idx_nx;

  logic [AW:0]      eff_steps, eff_m1;
  logic             enter, go_idle;
  logic [AW-1:0]    enter_idx;

  // Step table write port; addresses beyond the table are silently dropped.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dur_mem[i] <= '0;
        pat_mem[i] <= IDLE_PATTERN;
      end
    end else if (cfg_we && ({1'b0, cfg_addr} < DEPTH_W)) begin
      dur_mem[cfg_addr] <= cfg_dur;
      pat_mem[cfg_addr] <= cfg_pattern;
    end
  end

  // Next-state and next-output logic; entering a step reads the table here.
  always_comb begin
    eff_steps = (num_steps > DEPTH_W) ? DEPTH_W : num_steps;
    eff_m1    = eff_steps - STEP_ONE;
    state_nx  = state;
    cnt_nx    = cnt;
    last_nx   = last;
    passes_nx = passes;
    cont_nx   = cont;
    out_nx    = signal_out;
    busy_nx   = busy;
    idx_nx    = step_index;
    strobe_nx = 1'b0;
    done_nx   = 1'b0;
    enter     = 1'b0;
    enter_idx = '0;
    go_idle   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort && (eff_steps != '0)) begin
          state_nx  = ST_RUN;
          last_nx   = eff_m1[AW-1:0];
          passes_nx = repeat_count;
          cont_nx   = (repeat_count == 16'd0);
          enter     = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          go_idle = 1'b1;
        end else if (cnt != '0) begin
          cnt_nx = cnt - DUR_ONE;
        end else if (step_index != last) begin
          enter     = 1'b1;
          enter_idx = step_index + IDX_ONE;
        end else if (cont) begin
          enter = 1'b1;
        end else if (passes > 16'd1) begin
          passes_nx = passes - 16'd1;
          enter     = 1'b1;
        end else begin
          go_idle = 1'b1;
          done_nx = 1'b1;
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase
    if (enter) begin
      out_nx    = pat_mem[enter_idx];
      idx_nx    = enter_idx;
      cnt_nx    = dur_mem[enter_idx];
      strobe_nx = 1'b1;
      busy_nx   = 1'b1;
    end else if (go_idle) begin
      state_nx = ST_IDLE;
      out_nx   = IDLE_PATTERN;
      busy_nx  = 1'b0;
      idx_nx   = '0;
    end else begin
      // counting down inside the current step: outputs hold
      busy_nx = busy;
    end
  end

  // State, sequencing registers and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last        <= '0;
      passes      <= 16'd0;
      cont        <= 1'b0;
      signal_out  <= IDLE_PATTERN;
      busy        <= 1'b0;
      step_index  <= '0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      last        <= last_nx;
      passes      <= passes_nx;
      cont        <= cont_nx;
      signal_out  <= out_nx;
      busy        <= busy_nx;
      step_index  <= idx_nx;
      step_strobe <= strobe_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Testbench for pulse_sequencer: table-driven cycle vectors plus
// hand-written sequences for table writes, clamping, reset and range drop.
module tb_pulse_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [21:0] cfg_dur;
  logic [7:0]  cfg_pattern;
  logic [4:0]  num_steps;
  logic [15:0] repeat_count;
  logic        start, abort;
  logic [7:0]  signal_out;
  logic        busy, step_strobe, done;
  logic [3:0]  step_index;

  // second instance with a non power-of-two table for the range-drop case
  logic        d2_we, d2_start;
  logic [3:0]  d2_addr;
  logic [21:0] d2_dur;
  logic [7:0]  d2_pat, d2_out;
  logic [4:0]  d2_steps;
  logic        d2_busy, d2_strobe, d2_done;
  logic [3:0]  d2_idx;

  int checks = 0;
  int passed = 0;

  pulse_sequencer #(.DUR_W(22), .OUT_W(8), .DEPTH(16), .IDLE_PATTERN(8'h80)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_dur(cfg_dur), .cfg_pattern(cfg_pattern), .num_steps(num_steps),
    .repeat_count(repeat_count), .start(start), .abort(abort),
    .signal_out(signal_out), .busy(busy), .step_index(step_index),
    .step_strobe(step_strobe), .done(done));

  pulse_sequencer #(.DUR_W(22), .OUT_W(8), .DEPTH(12), .IDLE_PATTERN(8'h80)) dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_we(d2_we), .cfg_addr(d2_addr),
    .cfg_dur(d2_dur), .cfg_pattern(d2_pat), .num_steps(d2_steps),
    .repeat_count(16'd1), .start(d2_start), .abort(1'b0),
    .signal_out(d2_out), .busy(d2_busy), .step_index(d2_idx),
    .step_strobe(d2_strobe), .done(d2_done));

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       start;
    logic       abort;
    logic [7:0] out;
    logic       busy;
    logic       strobe;
    logic       done;
    logic [3:0] idx;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic add(input logic s, input logic a, input logic [7:0] o, input logic b,
                     input logic st, input logic d, input logic [3:0] i);
    vec_t v;
    v.start = s; v.abort = a; v.out = o; v.busy = b; v.strobe = st; v.done = d; v.idx = i;
    vecs.push_back(v);
  endtask

  // first n cycles of one pass over table {0:(2,88),1:(0,80),2:(4,90)}
  task automatic add_pass(input logic first_start, input int n);
    logic [3:0] ix;
    logic [7:0] o;
    for (int k = 0; k < n; k++) begin
      ix = (k < 3) ? 4'd0 : ((k == 3) ? 4'd1 : 4'd2);
      o  = (ix == 4'd0) ? 8'h88 : ((ix == 4'd1) ? 8'h80 : 8'h90);
      add((k == 0) ? first_start : 1'b0, 1'b0, o, 1'b1, (k == 0 || k == 3 || k == 4), 1'b0, ix);
    end
  endtask

  // record i drives inputs before edge i and expects outputs in cycle i+1
  task automatic run_vecs(input string tag);
    logic [15:0] got, exp;
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      tick();
      got = {signal_out, busy, step_strobe, done, step_index, 1'b0};
      exp = {vecs[i].out, vecs[i].busy, vecs[i].strobe, vecs[i].done, vecs[i].idx, 1'b0};
      checks++;
      if (got !== exp)
        $display("FAIL %s[%0d]: got out=%h busy=%b strobe=%b done=%b idx=%0d, expected out=%h busy=%b strobe=%b done=%b idx=%0d",
                 tag, i, signal_out, busy, step_strobe, done, step_index,
                 vecs[i].out, vecs[i].busy, vecs[i].strobe, vecs[i].done, vecs[i].idx);
      else passed++;
    end
    start = 1'b0;
    abort = 1'b0;
    vecs.delete();
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [21:0] d, input logic [7:0] p);
    cfg_we = 1'b1; cfg_addr = a; cfg_dur = d; cfg_pattern = p;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int busy_cyc, strobes;
    logic saw15, saw55, saw66, got_done;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_dur = '0; cfg_pattern = '0;
    num_steps = 5'd3; repeat_count = 16'd1; start = 1'b0; abort = 1'b0;
    d2_we = 1'b0; d2_start = 1'b0; d2_addr = '0; d2_dur = '0; d2_pat = '0; d2_steps = 5'd12;
    #6;
    check("reset_out", {24'd0, signal_out}, 32'h80);
    check("reset_ctl", {25'd0, busy, step_strobe, done, step_index}, 32'd0);
    #6 rst_n = 1'b1;
    tick();

    write_entry(4'd0, 22'd2, 8'h88);
    write_entry(4'd1, 22'd0, 8'h80);
    write_entry(4'd2, 22'd4, 8'h90);
    write_entry(4'd15, 22'd1, 8'h5A);

    // single pass, restart while done is high, abort, start+abort, abort on a D=0 step
    add_pass(1'b1, 9);
    add(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b1, 1'b0, 8'h88, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    add_pass(1'b1, 4);
    add(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    run_vecs("basic");

    // two passes back to back, done only after the second
    repeat_count = 16'd2;
    add_pass(1'b1, 9);
    add_pass(1'b0, 9);
    add(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 4'd0);
    add(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    run_vecs("repeat2");

    // continuous mode, abort at edge 25
    repeat_count = 16'd0;
    add_pass(1'b1, 9);
    add_pass(1'b0, 9);
    add_pass(1'b0, 7);
    add(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    run_vecs("continuous");

    // rewrite entry 2 while step 0 runs; the same pass picks it up
    repeat_count = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wr_step0", {24'd0, signal_out}, 32'h88);
    write_entry(4'd2, 22'd4, 8'hA0);
    tick(); tick(); tick();
    check("wr_step2", {19'd0, signal_out, step_strobe, step_index}, {19'd0, 8'hA0, 1'b1, 4'd2});
    wait_done("wr_done", 20);
    tick();

    // zero steps: start ignored
    num_steps = 5'd0;
    add(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 4'd0);
    run_vecs("nsteps0");

    // num_steps=20 clamps to 16: 3+1+5+12*1+2 = 23 busy cycles
    num_steps = 5'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cyc = 0; strobes = 0; saw15 = 1'b0; got_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cyc++;
      if (step_strobe === 1'b1) strobes++;
      if (step_strobe === 1'b1 && step_index == 4'd15 && signal_out == 8'h5A) saw15 = 1'b1;
      tick();
    end
    check("clamp_done", {31'd0, got_done}, 32'd1);
    check("clamp_busy", busy_cyc, 32'd23);
    check("clamp_strobes", strobes, 32'd16);
    check("clamp_step15", {31'd0, saw15}, 32'd1);
    tick();

    // asynchronous reset mid-step, then an unprogrammed run
    num_steps = 5'd3;
    repeat_count = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_out", {24'd0, signal_out}, 32'h80);
    check("arst_ctl", {25'd0, busy, step_strobe, done, step_index}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    repeat_count = 16'd1;
    add(1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 4'd1);
    add(1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 4'd2);
    add(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 4'd0);
    run_vecs("post_reset");

    // DEPTH=12 instance: write to address 12 dropped, address 11 kept
    d2_we = 1'b1; d2_addr = 4'd11; d2_dur = 22'd0; d2_pat = 8'h66;
    tick();
    d2_addr = 4'd12; d2_dur = 22'd3; d2_pat = 8'h55;
    tick();
    d2_we = 1'b0;
    d2_start = 1'b1;
    tick();
    d2_start = 1'b0;
    busy_cyc = 0; saw55 = 1'b0; saw66 = 1'b0; got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (d2_done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (d2_busy === 1'b1) busy_cyc++;
      if (d2_out == 8'h55) saw55 = 1'b1;
      if (d2_idx == 4'd11 && d2_out == 8'h66) saw66 = 1'b1;
      tick();
    end
    check("range_done", {31'd0, got_done}, 32'd1);
    check("range_busy", busy_cyc, 32'd12);
    check("range_drop", {31'd0, saw55}, 32'd0);
    check("range_keep", {31'd0, saw66}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
